// File: rtl/gate_envelope_pkg.sv
// Shared types and constants for the gate-driven envelope generator.
//   env_state_t : envelope FSM states
//   DEF_AMP_W   : default amplitude width
//   DEF_RATE_W  : default rate-prescaler width
//   AMP_MAX     : full-scale amplitude at the default width
package gate_envelope_pkg;

    localparam int unsigned DEF_AMP_W  = 8;
    localparam int unsigned DEF_RATE_W = 8;
    localparam int unsigned AMP_MAX    = (1 << DEF_AMP_W) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

endpackage

// File: rtl/gate_envelope_rate_prescaler.sv
// Programmable clock divider pacing envelope steps.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count from 0 (takes priority)
//   en       : count while high; held at 0 while low
//   rate     : clocks per tick, minus 1 (sampled live)
//   tick     : high in the cycle where cnt == rate (combinational from cnt)
module rate_prescaler
    import gate_envelope_pkg::*;
#(
    parameter int unsigned RATE_W = DEF_RATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [RATE_W-1:0] cnt;

    assign tick = en && (cnt == rate);

    // Wrap-to-zero counter; >= guards against rate being lowered mid-count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt >= rate) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + RATE_W'(1);
        end
    end

endmodule

// File: rtl/gate_envelope.sv
// Linear attack/release envelope driven by a stepped gate pattern.
//   clk, rst     : clock, asynchronous active-high reset
//   step         : one-cycle strobe, gate_in is sampled only when high
//   gate_in      : serial pattern bit
//   attack_rate  : clocks per attack increment, minus 1
//   release_rate : clocks per release decrement, minus 1
//   amp          : registered envelope amplitude
//   trig         : registered one-cycle note-on pulse
//   busy         : state != IDLE, decoded from the state register
module gate_envelope
    import gate_envelope_pkg::*;
#(
    parameter int unsigned AMP_W  = DEF_AMP_W,
    parameter int unsigned RATE_W = DEF_RATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              gate_in,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] release_rate,
    output logic [AMP_W-1:0]  amp,
    output logic              trig,
    output logic              busy
);

    // Full scale for the configured width (equals AMP_MAX at the default).
    localparam logic [AMP_W-1:0] AMP_FULL = '1;

    env_state_t        state, state_n;
    logic [AMP_W-1:0]  amp_n;
    logic              trig_n;
    logic              prev_gate, prev_gate_n;
    logic              trigger_c, note_off_c;
    logic              ps_clr, ps_en, ps_tick;
    logic [RATE_W-1:0] ps_rate;

    assign trigger_c  = step && gate_in && !prev_gate;
    assign note_off_c = step && !gate_in && ((state == ATTACK) || (state == SUSTAIN));

    assign ps_en   = (state == ATTACK) || (state == RELEASE);
    assign ps_rate = (state == ATTACK) ? attack_rate : release_rate;
    assign busy    = (state != IDLE);

    rate_prescaler #(
        .RATE_W (RATE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr),
        .en   (ps_en),
        .rate (ps_rate),
        .tick (ps_tick)
    );

    // State, amplitude, pulse and gate-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            amp       <= '0;
            trig      <= 1'b0;
            prev_gate <= 1'b0;
        end else begin
            state     <= state_n;
            amp       <= amp_n;
            trig      <= trig_n;
            prev_gate <= prev_gate_n;
        end
    end

    // Next-state logic; gate events override (and discard) a same-cycle tick.
    always_comb begin
        state_n     = state;
        amp_n       = amp;
        trig_n      = 1'b0;
        ps_clr      = 1'b0;
        prev_gate_n = step ? gate_in : prev_gate;

        if (trigger_c) begin
            state_n = ATTACK;
            trig_n  = 1'b1;
            ps_clr  = 1'b1;
        end else if (note_off_c) begin
            state_n = RELEASE;
            ps_clr  = 1'b1;
        end else begin
            unique case (state)
                ATTACK: begin
                    if (amp == AMP_FULL) begin
                        state_n = SUSTAIN;
                    end else if (ps_tick) begin
                        amp_n = amp + AMP_W'(1);
                        if (amp == AMP_FULL - AMP_W'(1)) begin
                            state_n = SUSTAIN;
                        end
                    end
                end
                RELEASE: begin
                    if (amp == '0) begin
                        state_n = IDLE;
                    end else if (ps_tick) begin
                        amp_n = amp - AMP_W'(1);
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_envelope.sv
// Directed self-checking bench for gate_envelope (default 8-bit widths).
module tb_gate_envelope;
    import gate_envelope_pkg::*;

    logic       clk;
    logic       rst;
    logic       step;
    logic       gate_in;
    logic [7:0] attack_rate;
    logic [7:0] release_rate;
    logic [7:0] amp;
    logic       trig;
    logic       busy;

    int vectors;
    int miscompares;

    gate_envelope #(
        .AMP_W  (8),
        .RATE_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .step         (step),
        .gate_in      (gate_in),
        .attack_rate  (attack_rate),
        .release_rate (release_rate),
        .amp          (amp),
        .trig         (trig),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a one-cycle step with the given gate bit; returns at the next negedge.
    task automatic step_pulse(input logic g);
        step    = 1'b1;
        gate_in = g;
        @(negedge clk);
        step    = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        step         = 1'b0;
        gate_in      = 1'b0;
        attack_rate  = 8'd0;
        release_rate = 8'd0;

        // Reset state
        wait_n(2);
        check("rst_amp",  32'(amp),  32'd0);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_n(1);

        // Attack at rate 0: trig for one cycle, amp +1 per cycle to full scale
        step_pulse(1'b1);
        check("atk_trig_hi", 32'(trig), 32'd1);
        check("atk_amp0",    32'(amp),  32'd0);
        check("atk_busy",    32'(busy), 32'd1);
        wait_n(1);
        check("atk_trig_lo", 32'(trig), 32'd0);
        check("atk_amp1",    32'(amp),  32'd1);
        wait_n(253);
        check("atk_amp254",  32'(amp),  32'd254);
        wait_n(1);
        check("atk_amp255",  32'(amp),  32'(AMP_MAX));
        wait_n(10);
        check("sus_no_wrap", 32'(amp),  32'(AMP_MAX));
        check("sus_busy",    32'(busy), 32'd1);

        // Gate held high over further steps: no retrigger
        for (int i = 0; i < 5; i++) begin
            step_pulse(1'b1);
            check("held_no_trig", 32'(trig), 32'd0);
            wait_n(1);
        end
        check("held_amp", 32'(amp), 32'(AMP_MAX));

        // Release at rate 3: one decrement per 4 cycles, IDLE 1020+1 cycles in
        release_rate = 8'd3;
        step_pulse(1'b0);
        check("rel_enter_amp", 32'(amp), 32'd255);
        wait_n(3);
        check("rel_amp_r3",    32'(amp), 32'd255);
        wait_n(1);
        check("rel_amp_r4",    32'(amp), 32'd254);
        wait_n(4);
        check("rel_amp_r8",    32'(amp), 32'd253);
        wait_n(1012);
        check("rel_amp_r1020", 32'(amp),  32'd0);
        check("rel_busy_r1020",32'(busy), 32'd1);
        wait_n(1);
        check("rel_idle_busy", 32'(busy), 32'd0);
        check("rel_idle_amp",  32'(amp),  32'd0);

        // Retrigger during RELEASE at amp 100 resumes attack from 100
        attack_rate = 8'd0;
        step_pulse(1'b1);
        check("rt_trig", 32'(trig), 32'd1);
        wait_n(255);
        check("rt_full", 32'(amp), 32'd255);
        step_pulse(1'b0);
        wait_n(620);
        check("rt_amp100", 32'(amp), 32'd100);
        step_pulse(1'b0);
        check("rt_ignore_off_amp",  32'(amp),  32'd100);
        check("rt_ignore_off_busy", 32'(busy), 32'd1);
        step_pulse(1'b1);
        check("rt_trig2",     32'(trig), 32'd1);
        check("rt_amp_hold",  32'(amp),  32'd100);
        wait_n(1);
        check("rt_trig2_lo",  32'(trig), 32'd0);
        check("rt_amp101",    32'(amp),  32'd101);
        wait_n(1);
        check("rt_amp102",    32'(amp),  32'd102);
        check("rt_one_pulse", 32'(trig), 32'd0);

        // Back to IDLE via fast release
        wait_n(160);
        release_rate = 8'd0;
        step_pulse(1'b0);
        wait_n(260);
        check("idle2_busy", 32'(busy), 32'd0);
        check("idle2_amp",  32'(amp),  32'd0);

        // Note-off coinciding with an attack tick at amp 50: tick discarded
        attack_rate  = 8'd3;
        release_rate = 8'd3;
        step_pulse(1'b1);
        wait_n(203);
        check("col_pre_amp", 32'(amp), 32'd50);
        step_pulse(1'b0);
        check("col_amp50",   32'(amp),  32'd50);
        check("col_busy",    32'(busy), 32'd1);
        wait_n(3);
        check("col_hold50",  32'(amp), 32'd50);
        wait_n(1);
        check("col_rel49",   32'(amp), 32'd49);

        // Reset mid-attack at amp 80, then the next high step triggers
        attack_rate = 8'd0;
        step_pulse(1'b1);
        check("ra_trig", 32'(trig), 32'd1);
        wait_n(31);
        check("ra_amp80", 32'(amp), 32'd80);
        rst = 1'b1;
        #1;
        check("ra_async_amp",  32'(amp),  32'd0);
        check("ra_async_busy", 32'(busy), 32'd0);
        check("ra_async_trig", 32'(trig), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_n(2);
        check("ra_post_amp",  32'(amp),  32'd0);
        check("ra_post_busy", 32'(busy), 32'd0);
        step_pulse(1'b1);
        check("ra_retrig",      32'(trig), 32'd1);
        check("ra_retrig_busy", 32'(busy), 32'd1);
        wait_n(1);
        check("ra_retrig_amp1", 32'(amp),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_envelope.md
GATE_ENVELOPE -- requirements
Module: gate_envelope

Interface
REQ-001 SHALL have parameter AMP_W, default 8, meaning amplitude width in bits.
REQ-002 SHALL have parameter RATE_W, default 8, meaning rate-prescaler width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port step  input  1  one-cycle step strobe; the same strobe that advances the upstream pattern rotator.
REQ-006 SHALL have port gate_in  input  1  serial pattern bit from the upstream rotator.
REQ-007 SHALL have port attack_rate  input  RATE_W  clocks per attack increment, minus 1.
REQ-008 SHALL have port release_rate  input  RATE_W  clocks per release decrement, minus 1.
REQ-009 SHALL have port amp  output  AMP_W  registered envelope amplitude.
REQ-010 SHALL have port trig  output  1  registered one-cycle note-on pulse.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-013 SHALL sample gate_in only on cycles with step=1, holding the last sampled value in prev_gate.
REQ-014 SHALL treat step=1, gate_in=1, prev_gate=0 as a trigger: next state ATTACK from any state, trig=1 on the following cycle, prescaler cleared, amp unchanged.
REQ-015 SHALL treat step=1, gate_in=0 while in ATTACK or SUSTAIN as note-off: next state RELEASE, prescaler cleared.
REQ-016 SHALL ignore step=1, gate_in=1, prev_gate=1 in every state (no retrigger while the gate is held).
REQ-017 SHALL ignore step=1, gate_in=0 in IDLE and RELEASE.
REQ-018 SHALL run a prescaler in ATTACK and RELEASE: tick when cnt==rate, then cnt<=0; otherwise cnt<=cnt+1; rate is the live attack_rate or release_rate input.
REQ-019 SHALL on an ATTACK tick set amp<=amp+1; when amp reaches 2^AMP_W-1 the next state is SUSTAIN, with no wrap.
REQ-020 SHALL on a RELEASE tick set amp<=amp-1; when amp==0 in RELEASE the next state is IDLE, with no decrement and no underflow.
REQ-021 SHALL hold amp constant in IDLE and SUSTAIN, with the prescaler held at 0.
REQ-022 SHALL give step events (REQ-014/015) priority over a prescaler tick in the same cycle; the tick is discarded.
REQ-023 SHALL make the first amp change visible rate+1 cycles after entering ATTACK or RELEASE; with rate=0, amp changes every cycle.
REQ-024 SHALL let a trigger during RELEASE restart ATTACK from the current amp, with no jump to 0.
REQ-025 SHALL clear trig on every cycle without a new trigger.

Reset
REQ-026 SHALL on rst force: state=IDLE, amp=0, trig=0, prev_gate=0, prescaler cnt=0, busy=0.
REQ-027 SHALL on rst asserted mid-ATTACK/RELEASE abort the envelope immediately, with no residual trig.
REQ-028 SHALL after rst release treat the first sampled gate_in=1 as a trigger, because prev_gate=0.

Structure
REQ-029 SHALL take the state enum (env_state_t) and the AMP_MAX / rate-width constants from shared package gate_envelope_pkg.
REQ-030 SHALL instantiate one sub-module, rate_prescaler (inputs clk, rst, clr, en, rate; output tick), for REQ-018.
REQ-031 SHALL keep all outputs registered, except busy, which is decoded from the state register.

Verification
REQ-032 SHALL cover: attack_rate=0, step with gate_in=1 -> trig high 1 cycle; amp 0 to 255 in 255 cycles; SUSTAIN; busy=1.
REQ-033 SHALL cover: from SUSTAIN, release_rate=3, step with gate_in=0 -> amp decrements every 4 cycles; IDLE after 1020 cycles plus 1; busy=0.
REQ-034 SHALL cover: attack_rate=0 with gate held high over 5 steps -> exactly one trig; amp saturates at 255 and never wraps.
REQ-035 SHALL cover: during RELEASE at amp=100, step with 0 then a step with 1 -> ATTACK resumes from 100; trig pulses once.
REQ-036 SHALL cover: step with gate_in=0 in the same cycle as an ATTACK tick at amp=50 -> RELEASE; amp stays 50 that cycle.
REQ-037 SHALL cover: rst pulsed mid-ATTACK at amp=80 -> amp=0, IDLE, trig=0; the next step with gate_in=1 triggers.
